load_store_align_unit: RTL
==========================

# load_store_align_unit

Parametrised load/store alignment unit between the core's memory stage and the data-memory port. It replaces purely combinational load extension with a sequenced engine. It generates byte strobes for stores and sign- or zero-extends load data, for any access size up to the data width. Accesses that cross a word boundary are split into two memory beats and recombined, which the combinational path cannot do. The core sees one request and one response per access.

## Interface
Parameters:
- XLEN, 32: data and word width in bits; legal values 32 or 64. BYTES = XLEN/8.
- ADDR_W, 32: byte-address width.
- MISALIGN_EN, 1: 1 = split boundary-crossing accesses; 0 = report them as errors.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core access request.
- req_ready  out  1  high only in IDLE; an access is accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 dword (legal only when XLEN=64).
- req_unsigned  in  1  load only: zero-extend when 1, sign-extend when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- rsp_valid  out  1  single-cycle completion pulse; the core cannot back-pressure it.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  1  illegal size, or misaligned access with MISALIGN_EN=0.
- mem_valid  out  1  memory beat request.
- mem_ready  in  1  memory accepts the beat when mem_valid && mem_ready.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  word-aligned beat address (low log2(BYTES) bits are 0).
- mem_wstrb  out  BYTES  byte-lane write enables; 0 on reads.
- mem_wdata  out  XLEN  lane-positioned write data.
- mem_rvalid  in  1  read data valid; only sampled in WAIT states.
- mem_rdata  in  XLEN  read data.

## Operation
- On acceptance, latch every request field. Derive:
  - off = addr mod BYTES;
  - nbytes = 1 << size;
  - cross = (off + nbytes > BYTES).
- Error check: an access is an error if size is illegal, or if cross && !MISALIGN_EN. On error, go to RESP with rsp_err=1 and issue no memory beat.
- Store lane shaping:
  - Form a 2*XLEN shifted value wdata << (8*off) and a 2*BYTES mask ((1<<nbytes)-1) << off.
  - Beat 0 takes the low halves at word address floor(addr/BYTES)*BYTES.
  - Beat 1, only when cross, takes the high halves at beat-0 address + BYTES.
- Load assembly:
  - Beat 0 data forms the low word and beat 1 data the high word of a 2*XLEN value; without cross, the high word is 0.
  - Shift that value right by 8*off and keep the low nbytes bytes.
  - Extend from bit 8*nbytes-1: with zeros if req_unsigned, otherwise with the sign bit. Word-size loads at XLEN=64 extend the same way.
- State machine states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- Transitions:
  - IDLE → REQ0 on acceptance, or → RESP if the access is an error.
  - REQ0 on mem accept → WAIT0 for a load; for a store → REQ1 if cross, else RESP.
  - WAIT0 on mem_rvalid (capture data) → REQ1 if cross, else RESP.
  - REQ1 on mem accept → WAIT1 for a load, RESP for a store.
  - WAIT1 on mem_rvalid (capture data) → RESP.
  - RESP → IDLE. rsp_valid is high for exactly this one cycle.
- mem_valid is high only in REQ0 and REQ1.

## Timing
- Reset values: req_ready=1, mem_valid=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0; state=IDLE.
- All outputs are registered or decoded from state only; there is no combinational path from req_* to mem_*.
- While mem_valid=1 and mem_ready=0, mem_addr, mem_we, mem_wstrb and mem_wdata hold stable.
- Memory returns mem_rvalid no earlier than the cycle after the beat is accepted. The unit keeps one beat outstanding.
- Minimum latencies, from acceptance in cycle N with mem_ready=1 and mem_rvalid one cycle after each accept:
  - aligned load: mem_valid at N+1, rsp_valid at N+3;
  - split load: rsp_valid at N+5;
  - aligned store: rsp_valid at N+2;
  - split store: rsp_valid at N+3;
  - error: rsp_valid at N+1.
- The next request can be accepted the cycle after rsp_valid, when the unit is back in IDLE.
- Reset mid-operation: all outputs go to their reset values immediately and asynchronously. No rsp_valid is produced for the aborted access. A stray mem_rvalid arriving in IDLE is ignored.

## Test plan
- Byte loads (XLEN=32): lb at 0x1003 with mem_rdata=0x80112233 → mem_addr=0x1000, rsp_rdata=0xFFFFFF80. The same access as lbu → 0x00000080.
- Aligned half store: sh at 0x1002 with wdata=0x0000BEEF → one beat, mem_addr=0x1000, wstrb=1100, wdata=0xBEEF0000, rsp_valid at N+2.
- Split load: lw at 0x1003 with beat 0 (0x1000) returning 0xAABBCCDD and beat 1 (0x1004) returning 0x11223344 → rsp_rdata=0x223344AA, rsp_err=0, rsp_valid at N+5.
- Split store with back-pressure: sw at 0x1006 with wdata=0x12345678, mem_ready held low for 3 cycles on each beat → beat 0 is 0x1004/1100/0x56780000, beat 1 is 0x1008/0011/0x00001234, and mem_* stay stable throughout each stall.
- Errors: with MISALIGN_EN=0, lh at 0x1003 → no mem_valid, rsp_valid at N+1, rsp_err=1, rsp_rdata=0. With XLEN=32, size=11 → the same response.
- Reset mid-access: assert rst_n=0 in WAIT1 of a split load → mem_valid=0 and req_ready=1 immediately, no rsp_valid. A mem_rvalid pulse after release is ignored, and the next aligned lw completes normally.

Source files
------------

// File: rtl/load_store_align_unit_if.sv
// Core request/response channel and data-memory port of the load/store alignment unit.
// The master modport is the environment side (core plus data memory); the slave
// modport is the alignment unit itself.
interface load_store_align_unit_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned BYTES = XLEN / 8;

  // Core side
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  // Data-memory side
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BYTES-1:0]  mem_wstrb;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/load_store_align_unit.sv
// Sequenced load/store alignment unit. Shapes store lanes, extends load data, and
// splits word-boundary-crossing accesses into two memory beats. One request in,
// one response out per access; one memory beat outstanding at a time.
module load_store_align_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  load_store_align_unit_if.slave bus
);
  localparam int unsigned BYTES = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  // Wide enough to hold off + nbytes without overflow
  localparam int unsigned CNT_W = OFF_W + 2;
  localparam int unsigned IDX_W = $clog2(XLEN);

  typedef enum logic [2:0] {StIdle, StReq0, StWait0, StReq1, StWait1, StResp} state_e;

  state_e              state_q;
  logic                we_q;
  logic                uns_q;
  logic                cross_q;
  logic [1:0]          size_q;
  logic [OFF_W-1:0]    off_q;
  logic [BYTES-1:0]    strb_hi_q;
  logic [XLEN-1:0]     wdata_hi_q;
  logic [XLEN-1:0]     rdata_lo_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [BYTES-1:0]    mem_wstrb_q;
  logic [XLEN-1:0]     mem_wdata_q;
  logic [XLEN-1:0]     rsp_rdata_q;
  logic                rsp_err_q;

  logic [OFF_W-1:0]    req_off;
  logic [CNT_W-1:0]    req_nbytes;
  logic                req_cross;
  logic                req_size_ok;
  logic                req_err;
  logic [ADDR_W-1:0]   req_word_addr;
  logic [2*XLEN-1:0]   req_wdata_sh;
  logic [2*BYTES-1:0]  req_strb_sh;
  logic [XLEN-1:0]     ld_hi;
  logic [XLEN-1:0]     ld_lo;
  logic [XLEN-1:0]     ld_word;
  logic [XLEN-1:0]     ld_result;

  // Keep the low (8 << size) bits of v and fill the rest with zeros or the sign bit.
  function automatic logic [XLEN-1:0] extend(logic [XLEN-1:0] v, logic [1:0] size,
                                             logic uns);
    logic [XLEN-1:0] r;
    int unsigned     nbits;
    logic            sign;
    nbits = 32'(8) << size;
    if (nbits >= XLEN) begin
      r = v;
    end else begin
      sign = uns ? 1'b0 : v[IDX_W'(nbits - 1)];
      for (int unsigned i = 0; i < XLEN; i++) begin
        r[i] = (i < nbits) ? v[i] : sign;
      end
    end
    return r;
  endfunction

  // Request decode: offset, size, boundary crossing and the error condition.
  always_comb begin
    req_off       = bus.req_addr[OFF_W-1:0];
    req_nbytes    = CNT_W'(1) << bus.req_size;
    req_cross     = ({2'b00, req_off} + req_nbytes) > CNT_W'(BYTES);
    req_size_ok   = (XLEN == 64) || (bus.req_size != 2'b11);
    req_err       = !req_size_ok || (req_cross && !MISALIGN_EN);
    req_word_addr = {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
  end

  // Store lane shaping across a double-word window: low half is beat 0, high half beat 1.
  always_comb begin
    int unsigned lo_b;
    int unsigned hi_b;
    lo_b         = 32'(req_off);
    hi_b         = lo_b + 32'(req_nbytes);
    req_wdata_sh = (2 * XLEN)'(bus.req_wdata) << {req_off, 3'b000};
    req_strb_sh  = '0;
    for (int unsigned i = 0; i < 2 * BYTES; i++) begin
      if ((i >= lo_b) && (i < hi_b)) begin
        req_strb_sh[i] = 1'b1;
      end
    end
  end

  // Load assembly: the final beat's data joins any earlier captured beat, then shift/extend.
  always_comb begin
    ld_hi     = (state_q == StWait1) ? bus.mem_rdata : '0;
    ld_lo     = (state_q == StWait1) ? rdata_lo_q : bus.mem_rdata;
    ld_word   = XLEN'({ld_hi, ld_lo} >> {off_q, 3'b000});
    ld_result = extend(ld_word, size_q, uns_q);
  end

  // Access sequencer with registered memory-beat and response fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      cross_q     <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= '0;
      strb_hi_q   <= '0;
      wdata_hi_q  <= '0;
      rdata_lo_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            size_q  <= bus.req_size;
            off_q   <= req_off;
            cross_q <= req_cross;
            if (req_err) begin
              // No memory beat is issued; respond straight away.
              rsp_err_q <= 1'b1;
              state_q   <= StResp;
            end else begin
              mem_we_q    <= bus.req_we;
              mem_addr_q  <= req_word_addr;
              mem_wstrb_q <= bus.req_we ? req_strb_sh[BYTES-1:0] : '0;
              mem_wdata_q <= bus.req_we ? req_wdata_sh[XLEN-1:0] : '0;
              strb_hi_q   <= bus.req_we ? req_strb_sh[2*BYTES-1:BYTES] : '0;
              wdata_hi_q  <= bus.req_we ? req_wdata_sh[2*XLEN-1:XLEN] : '0;
              state_q     <= StReq0;
            end
          end
        end
        StReq0: begin
          if (bus.mem_ready) begin
            if (!we_q) begin
              state_q <= StWait0;
            end else if (cross_q) begin
              mem_addr_q  <= mem_addr_q + ADDR_W'(BYTES);
              mem_wstrb_q <= strb_hi_q;
              mem_wdata_q <= wdata_hi_q;
              state_q     <= StReq1;
            end else begin
              state_q <= StResp;
            end
          end
        end
        StWait0: begin
          if (bus.mem_rvalid) begin
            if (cross_q) begin
              rdata_lo_q <= bus.mem_rdata;
              mem_addr_q <= mem_addr_q + ADDR_W'(BYTES);
              state_q    <= StReq1;
            end else begin
              rsp_rdata_q <= ld_result;
              state_q     <= StResp;
            end
          end
        end
        StReq1: begin
          if (bus.mem_ready) begin
            state_q <= we_q ? StResp : StWait1;
          end
        end
        StWait1: begin
          if (bus.mem_rvalid) begin
            rsp_rdata_q <= ld_result;
            state_q     <= StResp;
          end
        end
        StResp: begin
          // Return every output field to its idle value.
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wstrb_q <= '0;
          mem_wdata_q <= '0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake outputs decoded from state only.
  assign bus.req_ready = (state_q == StIdle);
  assign bus.mem_valid = (state_q == StReq0) || (state_q == StReq1);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
